// File: rtl/decode_queue.sv
// decode_queue: registered RV32I decode stage with a DEPTH-entry output queue.
// Instructions arrive from fetch over in_valid/in_ready, are decoded
// combinationally and written into a circular buffer. Issue consumes the
// head entry over out_valid/out_ready. in_ready and out_valid come straight
// from flops, so issue back-pressure has no combinational path to fetch.
//
// Optional feature macro: DECODE_RV32M_EN
//   defined   -> OP with funct7 0000001 (RV32M) is legal, out_muldiv = 1
//   undefined -> that encoding is illegal, out_muldiv is always 0
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             drop all queued entries and any same-cycle push/pop
//   in_valid/ready    fetch handshake; in_ready = (count < DEPTH)
//   in_instr, in_pc   raw instruction and its address
//   out_valid/ready   issue handshake; out_valid = (count != 0)
//   out_pc .. out_illegal  decoded head entry
//   count             occupancy, 0..DEPTH
module decode_queue #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              out_pc,
  output logic [10:0]                  out_class,
  output logic [4:0]                   out_rd,
  output logic [4:0]                   out_rs1,
  output logic [4:0]                   out_rs2,
  output logic [2:0]                   out_funct3,
  output logic                         out_alt,
  output logic [31:0]                  out_imm,
  output logic                         out_rd_we,
  output logic                         out_rs1_used,
  output logic                         out_rs2_used,
  output logic                         out_muldiv,
  output logic                         out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  // One-hot class bit positions
  localparam int unsigned C_LUI    = 0;
  localparam int unsigned C_AUIPC  = 1;
  localparam int unsigned C_JAL    = 2;
  localparam int unsigned C_JALR   = 3;
  localparam int unsigned C_BRANCH = 4;
  localparam int unsigned C_LOAD   = 5;
  localparam int unsigned C_STORE  = 6;
  localparam int unsigned C_OPIMM  = 7;
  localparam int unsigned C_OP     = 8;
  localparam int unsigned C_FENCE  = 9;
  localparam int unsigned C_SYSTEM = 10;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [10:0]     cls;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic            alt;
    logic [31:0]     imm;
    logic            rd_we;
    logic            rs1_used;
    logic            rs2_used;
    logic            muldiv;
    logic            illegal;
  } entry_t;

  // ---------------------------------------------------------------- decode
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [10:0] cls_raw;
  logic        m_enc;
  logic        op_ok;
  logic        illegal;
  logic [31:0] imm;
  entry_t      dec;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign rd     = in_instr[11:7];

`ifdef DECODE_RV32M_EN
  assign m_enc = cls_raw[C_OP] && (f7 == 7'b0000001);
`else
  assign m_enc = 1'b0;
`endif

  // Raw opcode class; an unknown opcode (including instr[1:0] != 11) gives 0
  always_comb begin
    cls_raw = '0;
    case (opcode)
      7'b0110111: cls_raw[C_LUI]    = 1'b1;
      7'b0010111: cls_raw[C_AUIPC]  = 1'b1;
      7'b1101111: cls_raw[C_JAL]    = 1'b1;
      7'b1100111: cls_raw[C_JALR]   = 1'b1;
      7'b1100011: cls_raw[C_BRANCH] = 1'b1;
      7'b0000011: cls_raw[C_LOAD]   = 1'b1;
      7'b0100011: cls_raw[C_STORE]  = 1'b1;
      7'b0010011: cls_raw[C_OPIMM]  = 1'b1;
      7'b0110011: cls_raw[C_OP]     = 1'b1;
      7'b0001111: cls_raw[C_FENCE]  = 1'b1;
      7'b1110011: cls_raw[C_SYSTEM] = 1'b1;
      default:    cls_raw = '0;
    endcase
  end

  // Legality checks on funct3/funct7 per class
  always_comb begin
    op_ok = (f7 == 7'b0000000) ||
            ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
            m_enc;
    illegal = (cls_raw == '0);
    if (cls_raw[C_JALR] && (f3 != 3'b000))
      illegal = 1'b1;
    if (cls_raw[C_BRANCH] && ((f3 == 3'b010) || (f3 == 3'b011)))
      illegal = 1'b1;
    if (cls_raw[C_LOAD] && ((f3 == 3'b011) || (f3[2:1] == 2'b11)))
      illegal = 1'b1;
    if (cls_raw[C_STORE] && (f3 >= 3'b011))
      illegal = 1'b1;
    if (cls_raw[C_OPIMM] && (f3 == 3'b001) && (f7 != 7'b0000000))
      illegal = 1'b1;
    if (cls_raw[C_OPIMM] && (f3 == 3'b101) &&
        (f7 != 7'b0000000) && (f7 != 7'b0100000))
      illegal = 1'b1;
    if (cls_raw[C_OP] && !op_ok)
      illegal = 1'b1;
  end

  // Immediate follows the raw opcode format even when the instruction is illegal
  always_comb begin
    imm = '0;
    if (cls_raw[C_JALR] || cls_raw[C_LOAD] || cls_raw[C_OPIMM] || cls_raw[C_SYSTEM])
      imm = {{20{in_instr[31]}}, in_instr[31:20]};
    else if (cls_raw[C_STORE])
      imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    else if (cls_raw[C_BRANCH])
      imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
             in_instr[11:8], 1'b0};
    else if (cls_raw[C_LUI] || cls_raw[C_AUIPC])
      imm = {in_instr[31:12], 12'h000};
    else if (cls_raw[C_JAL])
      imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
             in_instr[30:21], 1'b0};
  end

  // Assemble the decoded record written on a push
  always_comb begin
    dec          = '0;
    dec.pc       = in_pc;
    dec.cls      = illegal ? 11'h000 : cls_raw;
    dec.rd       = rd;
    dec.rs1      = in_instr[19:15];
    dec.rs2      = in_instr[24:20];
    dec.funct3   = f3;
    dec.imm      = imm;
    dec.illegal  = illegal;
    dec.alt      = !illegal && in_instr[30] &&
                   (cls_raw[C_OP] ||
                    (cls_raw[C_OPIMM] && ((f3 == 3'b001) || (f3 == 3'b101))));
    dec.rd_we    = !illegal && (rd != 5'd0) &&
                   (cls_raw[C_LUI] || cls_raw[C_AUIPC] || cls_raw[C_JAL] ||
                    cls_raw[C_JALR] || cls_raw[C_LOAD] || cls_raw[C_OPIMM] ||
                    cls_raw[C_OP] || (cls_raw[C_SYSTEM] && (f3 != 3'b000)));
    dec.rs1_used = !illegal &&
                   (cls_raw[C_JALR] || cls_raw[C_BRANCH] || cls_raw[C_LOAD] ||
                    cls_raw[C_STORE] || cls_raw[C_OPIMM] || cls_raw[C_OP]);
    dec.rs2_used = !illegal &&
                   (cls_raw[C_BRANCH] || cls_raw[C_STORE] || cls_raw[C_OP]);
    dec.muldiv   = !illegal && m_enc;
  end

  // ---------------------------------------------------------------- queue
  entry_t         mem [DEPTH];
  entry_t         head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count_nxt;
  logic           push;
  logic           pop;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else
      count_nxt = count + CW'(push) - CW'(pop);
  end

  // Occupancy, pointers and registered handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      count     <= count_nxt;
      in_ready  <= (count_nxt < CW'(DEPTH));
      out_valid <= (count_nxt != '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Entry storage; cleared on reset so the head outputs read zero afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++)
        mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= dec;
    end
  end

  assign head         = mem[rd_ptr];
  assign out_pc       = head.pc;
  assign out_class    = head.cls;
  assign out_rd       = head.rd;
  assign out_rs1      = head.rs1;
  assign out_rs2      = head.rs2;
  assign out_funct3   = head.funct3;
  assign out_alt      = head.alt;
  assign out_imm      = head.imm;
  assign out_rd_we    = head.rd_we;
  assign out_rs1_used = head.rs1_used;
  assign out_rs2_used = head.rs2_used;
  assign out_muldiv   = head.muldiv;
  assign out_illegal  = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Testbench for decode_queue: table of decode vectors plus hand-written
// sequences for full, simultaneous push/pop, flush and asynchronous reset.
module tb_decode_queue;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(DEPTH+1);
  localparam int unsigned NV    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_instr = '0;
  logic [PC_W-1:0]   in_pc = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PC_W-1:0]   out_pc;
  logic [10:0]       out_class;
  logic [4:0]        out_rd, out_rs1, out_rs2;
  logic [2:0]        out_funct3;
  logic              out_alt;
  logic [31:0]       out_imm;
  logic              out_rd_we, out_rs1_used, out_rs2_used, out_muldiv, out_illegal;
  logic [CW-1:0]     count;

  decode_queue #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_class(out_class), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_alt(out_alt), .out_imm(out_imm),
    .out_rd_we(out_rd_we), .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used),
    .out_muldiv(out_muldiv), .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [10:0] cls;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] imm;
    logic        we, r1, r2, md, ill;
  } vec_t;

  vec_t vt [NV];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic [31:0] instr, logic [10:0] cls, logic [4:0] rd,
                              logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3,
                              logic alt, logic [31:0] imm, logic we, logic r1,
                              logic r2, logic md, logic ill);
    vec_t v;
    v.instr = instr; v.cls = cls; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.alt = alt; v.imm = imm; v.we = we; v.r1 = r1; v.r2 = r2;
    v.md = md; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    //        instr         cls     rd  rs1 rs2 f3  alt imm           we r1 r2 md ill
    vt[0]  = mk(32'hFFF10093, 11'h080, 1,  2,  31, 0, 0, 32'hFFFFFFFF, 1, 1, 0, 0, 0);
    vt[1]  = mk(32'hFE000EE3, 11'h010, 29, 0,  0,  0, 0, 32'hFFFFFFFC, 0, 1, 1, 0, 0);
`ifdef DECODE_RV32M_EN
    vt[2]  = mk(32'h022081B3, 11'h100, 3,  1,  2,  0, 0, 32'h00000000, 1, 1, 1, 1, 0);
`else
    vt[2]  = mk(32'h022081B3, 11'h000, 3,  1,  2,  0, 0, 32'h00000000, 0, 0, 0, 0, 1);
`endif
    vt[3]  = mk(32'h00000000, 11'h000, 0,  0,  0,  0, 0, 32'h00000000, 0, 0, 0, 0, 1);
    vt[4]  = mk(32'h00001037, 11'h001, 0,  0,  0,  1, 0, 32'h00001000, 0, 0, 0, 0, 0);
    vt[5]  = mk(32'h407302B3, 11'h100, 5,  6,  7,  0, 1, 32'h00000000, 1, 1, 1, 0, 0);
    vt[6]  = mk(32'h008000EF, 11'h004, 1,  0,  8,  0, 0, 32'h00000008, 1, 0, 0, 0, 0);
    vt[7]  = mk(32'hFE21AE23, 11'h040, 28, 3,  2,  2, 0, 32'hFFFFFFFC, 0, 1, 1, 0, 0);
    vt[8]  = mk(32'hFE21BE23, 11'h000, 28, 3,  2,  3, 0, 32'hFFFFFFFC, 0, 0, 0, 0, 1);
    vt[9]  = mk(32'h300020F3, 11'h400, 1,  0,  0,  2, 0, 32'h00000300, 1, 0, 0, 0, 0);
    vt[10] = mk(32'h00000073, 11'h400, 0,  0,  0,  0, 0, 32'h00000000, 0, 0, 0, 0, 0);
    vt[11] = mk(32'h40109093, 11'h000, 1,  1,  1,  1, 0, 32'h00000401, 0, 0, 0, 0, 1);
    vt[12] = mk(32'h4010D093, 11'h080, 1,  1,  1,  5, 1, 32'h00000401, 1, 1, 0, 0, 0);
    vt[13] = mk(32'hFE002EE3, 11'h000, 29, 0,  0,  2, 0, 32'hFFFFFFFC, 0, 0, 0, 0, 1);
    vt[14] = mk(32'h00000013, 11'h080, 0,  0,  0,  0, 0, 32'h00000000, 0, 1, 0, 0, 0);
    vt[15] = mk(32'h00000012, 11'h000, 0,  0,  0,  0, 0, 32'h00000000, 0, 0, 0, 0, 1);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.count",     32'(count),     32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_pc",    32'(out_pc),    32'd0);
    chk("rst.out_imm",   out_imm,        32'd0);
    chk("rst.out_class", 32'(out_class), 32'd0);
    rst = 1'b0;

    // Decode table: push one, check next cycle, pop
    out_ready = 1'b1;
    for (int i = 0; i < int'(NV); i++) begin
      logic [PC_W-1:0] pc;
      pc = PC_W'(32'h100 + 32'(i) * 4);
      push_one(vt[i].instr, pc);
      chk($sformatf("v%0d.out_valid", i), 32'(out_valid),    32'd1);
      chk($sformatf("v%0d.pc", i),        32'(out_pc),       32'(pc));
      chk($sformatf("v%0d.class", i),     32'(out_class),    32'(vt[i].cls));
      chk($sformatf("v%0d.rd", i),        32'(out_rd),       32'(vt[i].rd));
      chk($sformatf("v%0d.rs1", i),       32'(out_rs1),      32'(vt[i].rs1));
      chk($sformatf("v%0d.rs2", i),       32'(out_rs2),      32'(vt[i].rs2));
      chk($sformatf("v%0d.funct3", i),    32'(out_funct3),   32'(vt[i].f3));
      if (!vt[i].ill)
        chk($sformatf("v%0d.alt", i),     32'(out_alt),      32'(vt[i].alt));
      chk($sformatf("v%0d.imm", i),       out_imm,           vt[i].imm);
      chk($sformatf("v%0d.rd_we", i),     32'(out_rd_we),    32'(vt[i].we));
      chk($sformatf("v%0d.rs1_used", i),  32'(out_rs1_used), 32'(vt[i].r1));
      chk($sformatf("v%0d.rs2_used", i),  32'(out_rs2_used), 32'(vt[i].r2));
      chk($sformatf("v%0d.muldiv", i),    32'(out_muldiv),   32'(vt[i].md));
      chk($sformatf("v%0d.illegal", i),   32'(out_illegal),  32'(vt[i].ill));
    end
    @(negedge clk);
    chk("drain.count", 32'(count), 32'd0);

    // Full: three back-to-back pushes with out_ready low
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h200;
    @(negedge clk); in_instr = 32'h00200093; in_pc = 32'h204;
    @(negedge clk);
    chk("full.count2",    32'(count),    32'd2);
    chk("full.in_ready0", 32'(in_ready), 32'd0);
    in_instr = 32'h00300093; in_pc = 32'h208;
    @(negedge clk);
    chk("full.count_hold", 32'(count),    32'd2);
    chk("full.head0",      32'(out_pc),   32'h200);
    chk("full.imm0",       out_imm,       32'd1);
    chk("full.in_ready_pop_cycle", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("full.head1",      32'(out_pc),   32'h204);
    chk("full.imm1",       out_imm,       32'd2);
    chk("full.count1",     32'(count),    32'd1);
    chk("full.in_ready1",  32'(in_ready), 32'd1);
    @(negedge clk);
    chk("full.count0",     32'(count),     32'd0);
    chk("full.out_valid0", 32'(out_valid), 32'd0);

    // Simultaneous push and pop keeps count unchanged
    out_ready = 1'b0;
    push_one(32'h00100093, 32'h300);
    chk("pp.count1", 32'(count), 32'd1);
    in_valid = 1'b1; in_instr = 32'h00200093; in_pc = 32'h304; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pp.count_same", 32'(count),  32'd1);
    chk("pp.head",       32'(out_pc), 32'h304);
    @(negedge clk);
    chk("pp.count0", 32'(count), 32'd0);

    // Flush with a same-cycle push and pop request
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h400;
    @(negedge clk); in_pc = 32'h404;
    @(negedge clk);
    chk("fl.count2", 32'(count), 32'd2);
    flush = 1'b1; in_pc = 32'h408; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl.count0",     32'(count),     32'd0);
    chk("fl.out_valid0", 32'(out_valid), 32'd0);
    chk("fl.in_ready1",  32'(in_ready),  32'd1);
    @(negedge clk);
    chk("fl.count_stay0", 32'(count), 32'd0);

    // Asynchronous reset mid-cycle
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h500;
    @(negedge clk); in_pc = 32'h504;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar.count2", 32'(count), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("ar.count0",     32'(count),     32'd0);
    chk("ar.out_valid0", 32'(out_valid), 32'd0);
    chk("ar.in_ready1",  32'(in_ready),  32'd1);
    chk("ar.out_pc0",    32'(out_pc),    32'd0);
    chk("ar.out_imm0",   out_imm,        32'd0);
    chk("ar.out_rd0",    32'(out_rd),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
